// File: rtl/shift_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shift_pkg
//  Purpose  : Shared constants for the shift units: FSM state encodings,
//             default datapath widths and shift-kind codes.
//  Revision : 1.0 - initial release
// ============================================================================
package shift_pkg;

    localparam int DEF_WIDTH   = 32;
    localparam int DEF_SHAMT_W = 5;

    // Shift kind as carried on in_arith
    localparam logic SH_LOGIC = 1'b0;
    localparam logic SH_ARITH = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : shift_pkg
`default_nettype wire

// File: rtl/shr_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shr_stage
//  Purpose  : One combinational right-shift stage by a fixed distance DIST.
//             Vacated upper bits take the fill value; en=0 passes data through.
//  Revision : 1.0 - initial release
// ============================================================================
module shr_stage #(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data,
    input  logic             fill,
    input  logic             en,
    output logic [WIDTH-1:0] result
);

    // Fill bits are prepended, then the whole vector is shifted down so the
    // low DIST data bits fall off the end.
    logic [WIDTH+DIST-1:0] ext;

    assign ext    = {{DIST{fill}}, data};
    assign result = en ? WIDTH'(ext >> DIST) : data;

endmodule : shr_stage
`default_nettype wire

// File: rtl/shr_32_iter.sv
`default_nettype none
// ============================================================================
//  Module   : shr_32_iter
//  Purpose  : Multi-cycle logarithmic right shifter (SRL / SRA). One shamt bit
//             is applied per clock (distances 1,2,4,...), so every operation
//             takes exactly SHAMT_W cycles. Valid/ready on both sides.
//  Revision : 1.0 - initial release
// ============================================================================
module shr_32_iter
    import shift_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int SHAMT_W = DEF_SHAMT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_arith,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data
);

    localparam int STAGE_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    state_t               state;
    state_t               state_nxt;
    logic [WIDTH-1:0]     data_r;
    logic [SHAMT_W-1:0]   shamt_r;
    logic                 fill_r;
    logic [STAGE_W-1:0]   stage_r;
    logic [WIDTH-1:0]     stage_out [SHAMT_W];
    logic [WIDTH-1:0]     stage_res;
    logic                 accept;
    logic                 last_stage;

    // One fixed-distance stage per shamt bit; each is enabled by its own bit
    generate
        for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
            shr_stage #(
                .WIDTH (WIDTH),
                .DIST  (1 << k)
            ) u_stage (
                .data   (data_r),
                .fill   (fill_r),
                .en     (shamt_r[k]),
                .result (stage_out[k])
            );
        end
    endgenerate

    // Pick the stage that corresponds to the current iteration
    always_comb begin
        stage_res = data_r;
        for (int k = 0; k < SHAMT_W; k++) begin
            if (stage_r == STAGE_W'(k)) begin
                stage_res = stage_out[k];
            end
        end
    end

    assign last_stage = (stage_r == STAGE_W'(SHAMT_W - 1));
    assign accept     = in_valid & in_ready;
    assign out_valid  = (state == ST_DONE);

    // Next-state and input-side ready; ready never looks at in_valid
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (last_stage) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_nxt = in_valid ? ST_SHIFT : ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture, per-cycle stage application and result load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r   <= '0;
            shamt_r  <= '0;
            fill_r   <= 1'b0;
            stage_r  <= '0;
            out_data <= '0;
        end else if (accept) begin
            data_r  <= in_data;
            shamt_r <= in_shamt;
            // Fill is frozen here; later stages never look at the sign again
            fill_r  <= (in_arith == SH_ARITH) & in_data[WIDTH-1];
            stage_r <= '0;
        end else if (state == ST_SHIFT) begin
            data_r  <= stage_res;
            stage_r <= stage_r + 1'b1;
            if (last_stage) begin
                out_data <= stage_res;
            end
        end
    end

endmodule : shr_32_iter
`default_nettype wire

// File: tb/tb_shr_32_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shr_32_iter
//  Purpose  : Self-checking bench for shr_32_iter: directed corner cases and a
//             randomized regression against a >> / >>> reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shr_32_iter;

    localparam int N_RAND    = 10000;
    localparam int CYC_LIMIT = 95000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic        in_arith;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    int          checks;
    int          errors;
    logic [31:0] exp_r;

    shr_32_iter #(
        .WIDTH   (32),
        .SHAMT_W (5)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_arith  (in_arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain Verilog shift operators on the whole word
    function automatic logic [31:0] ref_shr(input logic [31:0] d, input logic [4:0] s,
                                            input logic a);
        logic signed [31:0] sd;
        sd = d;
        if (a) return 32'(sd >>> s);
        return d >> s;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Present an operand (call at a negedge); expected result given directly
    task automatic drive_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                            input logic [31:0] e);
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_arith = a;
        exp_r    = e;
    endtask

    // Accept on the coming posedge, then count cycles to out_valid
    task automatic wait_done(input string tag, input bit pulse);
        int n;
        @(posedge clk);
        @(negedge clk);
        n         = 0;
        out_ready = 1'b0;
        check({tag, "_ov_after_accept"}, 32'(out_valid), 32'd0);
        in_valid  = pulse;
        in_data   = $urandom;
        in_shamt  = 5'($urandom);
        in_arith  = 1'($urandom);
        while (!out_valid && n < 20) begin
            check({tag, "_busy_rdy"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_latency"}, 32'(n), 32'd5);
        check({tag, "_data"}, out_data, exp_r);
    endtask

    // Consume the result with nothing new offered (call at a negedge)
    task automatic release_result(input string tag);
        out_ready = 1'b1;
        in_valid  = 1'b0;
        #1;
        check({tag, "_done_rdy"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        check({tag, "_ov_cleared"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] q[$];
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] hold_val;
        bit          have_op;
        int          sent;
        int          recv;
        int          cyc;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_arith  = 1'b0;
        out_ready = 1'b0;
        exp_r     = '0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // SRL of the top bit all the way down
        drive_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001);
        wait_done("srl31", 1'b0);
        release_result("srl31");

        // Arithmetic shifts, negative and positive, including the maximum
        drive_op(32'h8000_0000, 5'd4, 1'b1, 32'hF800_0000);
        wait_done("sra4", 1'b0);
        release_result("sra4");
        drive_op(32'h7FFF_FFFF, 5'd16, 1'b1, 32'h0000_7FFF);
        wait_done("sra16", 1'b0);
        release_result("sra16");
        drive_op(32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF);
        wait_done("sra31", 1'b0);
        release_result("sra31");

        // Zero shift still takes full latency; busy in_valid is ignored
        drive_op(32'hDEAD_BEEF, 5'd0, 1'b1, 32'hDEAD_BEEF);
        wait_done("sh0", 1'b1);

        // Backpressure in DONE, then same-edge handoff to a new operand
        hold_val = out_data;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_data", out_data, hold_val);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        drive_op(32'h0000_F000, 5'd12, 1'b0, 32'h0000_000F);
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'd1);
        wait_done("b2b", 1'b0);
        release_result("b2b");

        // Asynchronous reset in the middle of the third shift cycle
        drive_op(32'h1234_5678, 5'd5, 1'b0, 32'h0);
        @(posedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive_op(32'h0000_0100, 5'd8, 1'b0, 32'h0000_0001);
        wait_done("post_rst", 1'b0);
        release_result("post_rst");

        // Randomized regression with random backpressure
        have_op = 1'b0;
        sent    = 0;
        recv    = 0;
        cyc     = 0;
        while (recv < N_RAND && cyc < CYC_LIMIT) begin
            @(negedge clk);
            cyc++;
            if (!have_op && sent < N_RAND && $urandom_range(0, 7) != 0) begin
                d = $urandom;
                case ($urandom_range(0, 5))
                    0:       s = 5'd0;
                    1:       s = 5'd31;
                    default: s = 5'($urandom);
                endcase
                a = 1'($urandom);
                have_op = 1'b1;
            end
            in_valid = have_op;
            if (have_op) begin
                in_data  = d;
                in_shamt = s;
                in_arith = a;
            end else begin
                in_data  = $urandom;
                in_shamt = 5'($urandom);
                in_arith = 1'($urandom);
            end
            out_ready = ($urandom_range(0, 7) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rnd_extra_result", 32'd1, 32'd0);
                end else begin
                    check("rnd_data", out_data, q.pop_front());
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_shr(d, s, a));
                sent++;
                have_op = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_received", 32'(recv), 32'(N_RAND));
        check("rnd_sent", 32'(sent), 32'(N_RAND));
        check("rnd_queue_empty", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_shr_32_iter
`default_nettype wire

// File: doc/shr_32_iter.md
Name: shr_32_iter

Overview:
- Multi-cycle right shifter; the counterpart of the combinational left shifter used for SLL.
- Implements SRL (logical, zero fill) and SRA (arithmetic, sign fill) for the multi-cycle datapath variant.
- Logarithmic algorithm, one shamt bit per clock, stages 1/2/4/8/16.
- Valid/ready handshake on both input and output so the execute stage can stall on it.

Parameters:
WIDTH, 32, data width in bits (power of two)
SHAMT_W, 5, shift-amount width; equals log2(WIDTH); also the shift latency in cycles

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand presented
in_ready  output  1  block can accept an operand this cycle
in_data  input  WIDTH  value to shift (rt)
in_shamt  input  SHAMT_W  shift amount
in_arith  input  1  1 = SRA (sign fill), 0 = SRL (zero fill)
out_valid  output  1  result available
out_ready  input  1  consumer takes result this cycle
out_data  output  WIDTH  shifted result (rd)

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state=IDLE; out_valid=0; out_data=0; in_ready=1; internal data/shamt/fill/stage regs=0.
- States: IDLE, SHIFT, DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational; no in_valid dependence.
- Accept (in_valid & in_ready at a clock edge):
  - latch data=in_data, shamt=in_shamt, stage=0.
  - fill = in_arith & in_data[WIDTH-1]; fill is captured at accept and never recomputed.
  - go to SHIFT.
- SHIFT, each cycle:
  - if shamt[stage]: data <= {{(1<<stage){fill}}, data[WIDTH-1:(1<<stage)]}; else data unchanged.
  - stage increments.
  - when stage==SHAMT_W-1 the final step is applied, out_data is loaded with the result and the state goes to DONE.
- Latency: fixed at SHAMT_W cycles from accept edge to out_valid=1, independent of shamt (shamt=0 still takes 5 cycles). No early exit.
- DONE:
  - out_valid=1; out_data held stable until out_ready=1.
  - out_valid & out_ready & !in_valid -> IDLE, out_valid=0 next cycle.
  - out_valid & out_ready & in_valid -> new operand accepted in the same cycle, go directly to SHIFT, out_valid=0 next cycle. Back-to-back throughput: one result per SHAMT_W+1 cycles.
- out_data keeps the last result after handshake until the next result loads; it is only meaningful while out_valid=1.
- in_valid while busy (SHIFT, or DONE without out_ready): ignored, no latch; upstream must hold its operand.
- in_* values are sampled only at the accept edge; changes afterwards have no effect.
- Reset asserted mid-SHIFT or in DONE: the operation is aborted and the result is lost. After rst_n rises the block is in IDLE and can accept on the first edge.
- Width rule: the shift is modulo-free; shamt values are 0..WIDTH-1 and every value is legal.
- Boundary results:
  - SRA by WIDTH-1 yields all-ones if negative, zero otherwise.
  - SRL by WIDTH-1 yields bit 31 in bit 0.

Decomposition:
- shift_pkg (shared constants header): state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2; WIDTH/SHAMT_W defaults; shift-kind constants SH_LOGIC=1'b0, SH_ARITH=1'b1.
- Reused by the SLL/SRL/SRA shift-unit wrapper and the ALU control decode.
- One sub-module, shr_stage: combinational single right stage with parameter DIST, inputs data, fill, en.
- The FSM indexes the stage result with a mux over the five DIST instances (1,2,4,8,16) selected by stage. Alternatively use lib mux_32 per stage, with its sel bit = shamt[stage] & (stage==k).

Test Plan:
1. Reset, then SRL in_data=0x80000000, shamt=31, arith=0 -> out_valid rises exactly 5 cycles after accept, out_data=0x00000001.
2. SRA 0x80000000 shamt=4 -> 0xF8000000; SRA 0x7FFFFFFF shamt=16 -> 0x00007FFF; SRA 0xFFFFFFFF shamt=31 -> 0xFFFFFFFF.
3. shamt=0, in_data=0xDEADBEEF, arith=1 -> 0xDEADBEEF after the full 5-cycle latency; in_ready=0 during SHIFT; in_valid pulses while busy are not accepted.
4. Backpressure: hold out_ready=0 for 3 cycles in DONE -> out_valid=1, out_data stable, in_ready=0. Then out_ready=1 with in_valid=1 (SRL 0x0000F000 shamt=12) -> same-edge accept, next result 0x0000000F.
5. Assert rst_n=0 asynchronously mid-cycle during SHIFT stage 2 -> out_valid=0 and out_data=0 immediately, without waiting for a clock edge. After release in_ready=1 and a fresh SRL 0x00000100 shamt=8 gives 0x00000001.
6. Random regression: 10k operands with random data/shamt/arith and random out_ready, checked against reference >> and >>>. Zero mismatches, no dropped or duplicated results.
